audio_i2s_tx: RTL and testbench

- Consumer end of the PSG sample interface.
- Paces the audio pipeline: issues the one-clock `next_sample` request once per frame, then latches the returned 16-bit `left_audio`/`right_audio` words.
- Serializes the latched words to an external stereo DAC in standard I2S format: MSB first, one-bit delay after each LRCK edge, LRCK low for left.
- Sits between the audio sources (PSG, future mixer) and the board-level DAC pins.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_i2s_tx_if.sv | 22 ++
 rtl/audio_i2s_tx.sv | 114 +++++++++++
 tb/tb_audio_i2s_tx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and the I2S transmitter state type.
package audio_pkg;

    localparam int AUDIO_SAMPLE_W      = 16;
    localparam int I2S_SLOTS_PER_CH    = 32;
    localparam int I2S_DATA_FIRST_SLOT = 1;
    localparam int I2S_DATA_LAST_SLOT  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_e;

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample request/return bus between an audio source and the I2S transmitter.
// Carries the mute request only when AUDIO_I2S_TX_MUTE_EN is defined.
interface audio_i2s_tx_if;
    import audio_pkg::*;

    logic                      next_sample;
    logic [AUDIO_SAMPLE_W-1:0] left_audio;
    logic [AUDIO_SAMPLE_W-1:0] right_audio;
`ifdef AUDIO_I2S_TX_MUTE_EN
    logic                      mute;
`endif

    // master = the transmitter pulling samples; slave = the audio source
`ifdef AUDIO_I2S_TX_MUTE_EN
    modport master (output next_sample, input left_audio, right_audio, mute);
    modport slave  (input next_sample, output left_audio, right_audio, mute);
`else
    modport master (output next_sample, input left_audio, right_audio);
    modport slave  (input next_sample, output left_audio, right_audio);
`endif

endinterface

// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: requests one sample pair per 64-BCK frame and shifts it out MSB first.
// Optional AUDIO_I2S_TX_MUTE_EN adds a frame-aligned mute on the sample bus.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int BCK_LOG2 = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    audio_i2s_tx_if.master smp,
    output logic           i2s_bck,
    output logic           i2s_lrck,
    output logic           i2s_data
);

    localparam int              CNT_W   = 6 + BCK_LOG2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    i2s_state_e                r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [AUDIO_SAMPLE_W-1:0] r_l_hold;
    logic [AUDIO_SAMPLE_W-1:0] r_r_hold;
    logic                      r_bck;
    logic                      r_lrck;
    logic                      r_data;

    i2s_state_e                w_state_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic                      w_capture;
    logic                      w_next_sample;
    logic                      w_bck;
    logic                      w_lrck;
    logic                      w_data;
    logic [5:0]                w_slot;
    logic [4:0]                w_bit;
    logic [3:0]                w_idx;
    logic [AUDIO_SAMPLE_W-1:0] w_word;

    assign w_slot = r_cnt[CNT_W-1 -: 6];
    assign w_bit  = w_slot[4:0];
    assign w_word = w_slot[5] ? r_r_hold : r_l_hold;
    // slot 1 carries the MSB, slot 16 the LSB
    assign w_idx  = 4'(5'(AUDIO_SAMPLE_W) - w_bit);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_capture     = 1'b0;
        w_next_sample = 1'b0;
        w_bck         = 1'b0;
        w_lrck        = 1'b0;
        w_data        = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (enable) w_state_nxt = RUN;
            end
            RUN: begin
                w_next_sample = (r_cnt == '0);
                w_cnt_nxt     = r_cnt + CNT_W'(1);
                w_bck         = r_cnt[BCK_LOG2-1];
                w_lrck        = w_slot[5];
                if (w_bit >= 5'(I2S_DATA_FIRST_SLOT) && w_bit <= 5'(I2S_DATA_LAST_SLOT))
                    w_data = w_word[w_idx];
                if (r_cnt == CNT_MAX) begin
                    w_capture = 1'b1;
                    // leaving RUN: pins go quiet on the same edge IDLE is entered
                    if (!enable) begin
                        w_state_nxt = IDLE;
                        w_bck       = 1'b0;
                        w_lrck      = 1'b0;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_l_hold <= '0;
            r_r_hold <= '0;
            r_bck    <= 1'b0;
            r_lrck   <= 1'b0;
            r_data   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bck   <= w_bck;
            r_lrck  <= w_lrck;
            r_data  <= w_data;
            if (w_capture) begin
`ifdef AUDIO_I2S_TX_MUTE_EN
                r_l_hold <= smp.mute ? '0 : smp.left_audio;
                r_r_hold <= smp.mute ? '0 : smp.right_audio;
`else
                r_l_hold <= smp.left_audio;
                r_r_hold <= smp.right_audio;
`endif
            end
        end
    end

    assign smp.next_sample = w_next_sample;
    assign i2s_bck         = r_bck;
    assign i2s_lrck        = r_lrck;
    assign i2s_data        = r_data;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx at BCK_LOG2 = 3 (512 clk per frame).
// Mute steps are compiled in only when AUDIO_I2S_TX_MUTE_EN is defined.
module tb_audio_i2s_tx;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic i2s_bck;
    logic i2s_lrck;
    logic i2s_data;

    int n_cmp  = 0;
    int n_fail = 0;

    audio_i2s_tx_if bus ();

    audio_i2s_tx #(.BCK_LOG2(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .smp      (bus),
        .i2s_bck  (i2s_bck),
        .i2s_lrck (i2s_lrck),
        .i2s_data (i2s_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pins();
        return {bus.next_sample, i2s_bck, i2s_lrck, i2s_data};
    endfunction

    // Entered at frame offset 0 (first RUN clk), leaves at offset 0 of the next frame.
    task automatic frame_check(input string tag, input logic [15:0] el, input logic [15:0] er,
                               input bit from_idle, input int drop_at);
        int ns_bad = 0, bck_bad = 0, lrck_bad = 0, data_bad = 0;
        logic [15:0] gl = '0, gr = '0, w;
        logic eb, elr, ed;
        int p, slot, b;
        check({tag, "_ns_start"}, 32'(bus.next_sample), 32'd1);
        for (int off = 0; off < 512; off++) begin
            if (off > 0 && bus.next_sample !== 1'b0) ns_bad++;
            if (off == 0) begin
                eb  = !from_idle;
                elr = !from_idle;
                ed  = 1'b0;
            end else begin
                p    = off - 1;
                slot = p / 8;
                b    = slot % 32;
                w    = (slot >= 32) ? er : el;
                eb   = ((p / 4) % 2) == 1;
                elr  = (p / 256) == 1;
                ed   = (b >= 1 && b <= 16) ? w[16-b] : 1'b0;
            end
            if (i2s_bck  !== eb)  bck_bad++;
            if (i2s_lrck !== elr) lrck_bad++;
            if (i2s_data !== ed)  data_bad++;
            if (off % 8 == 4) begin
                slot = off / 8;
                b    = slot % 32;
                if (b >= 1 && b <= 16) begin
                    if (slot >= 32) gr[16-b] = i2s_data;
                    else            gl[16-b] = i2s_data;
                end
            end
            if (off == drop_at) enable = 1'b0;
            tick();
        end
        check({tag, "_ns_extra"}, 32'(ns_bad), 32'd0);
        check({tag, "_bck_bad"},  32'(bck_bad), 32'd0);
        check({tag, "_lrck_bad"}, 32'(lrck_bad), 32'd0);
        check({tag, "_data_bad"}, 32'(data_bad), 32'd0);
        check({tag, "_left"},     32'(gl), 32'(el));
        check({tag, "_right"},    32'(gr), 32'(er));
    endtask

    initial begin
        int nz;
        int ns_cnt;

        rst_n           = 1'b0;
        enable          = 1'b0;
        bus.left_audio  = '0;
        bus.right_audio = '0;
`ifdef AUDIO_I2S_TX_MUTE_EN
        bus.mute        = 1'b0;
`endif
        repeat (4) tick();
        check("reset_pins", 32'(pins()), 32'd0);

        rst_n  = 1'b1;
        nz     = 0;
        ns_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if ({i2s_bck, i2s_lrck, i2s_data} !== 3'b000) nz++;
            if (bus.next_sample !== 1'b0) ns_cnt++;
        end
        check("idle_pins_nonzero", 32'(nz), 32'd0);
        check("idle_ns_pulses", 32'(ns_cnt), 32'd0);

        bus.left_audio  = 16'hA5C3;
        bus.right_audio = 16'h8001;
        enable          = 1'b1;
        tick();
        frame_check("f0", 16'h0000, 16'h0000, 1'b1, -1);
        frame_check("f1", 16'hA5C3, 16'h8001, 1'b0, -1);
        frame_check("f2", 16'hA5C3, 16'h8001, 1'b0, -1);

        // enable dropped at cnt 100: frame finishes, then IDLE
        frame_check("f3", 16'hA5C3, 16'h8001, 1'b0, 100);
        check("drop_idle_pins", 32'(pins()), 32'd0);
        nz = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (pins() !== 4'b0000) nz++;
        end
        check("drop_idle_nonzero", 32'(nz), 32'd0);

        bus.left_audio  = 16'h1234;
        bus.right_audio = 16'hFEDC;
        enable          = 1'b1;
        tick();
        check("reen_ns", 32'(bus.next_sample), 32'd1);
        repeat (300) tick();
        check("pre_rst_lrck", 32'(i2s_lrck), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rst_mid_pins", 32'(pins()), 32'd0);
        rst_n = 1'b1;
        tick();
        frame_check("f5", 16'h0000, 16'h0000, 1'b1, -1);
        frame_check("f6", 16'h1234, 16'hFEDC, 1'b0, -1);

`ifdef AUDIO_I2S_TX_MUTE_EN
        bus.left_audio  = 16'h7FFF;
        bus.right_audio = 16'h7FFF;
        bus.mute        = 1'b1;
        frame_check("m0", 16'h1234, 16'hFEDC, 1'b0, -1);
        bus.mute        = 1'b0;
        frame_check("m1", 16'h0000, 16'h0000, 1'b0, -1);
        frame_check("m2", 16'h7FFF, 16'h7FFF, 1'b0, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
